uart_mem_cmd_ctrl: RTL and testbench

Byte-level command sequencer between the UART engine and the cell RAM. It parses received bytes into write and read commands, drives the single-port RAM, and schedules one reply byte per command on the UART transmitter. It is the only master of both the RAM port and the transmitter, so commands are strictly serialized.

---
 rtl/uart_mem_cmd_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_uart_mem_cmd_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_mem_cmd_ctrl
// Description : Byte command sequencer between the UART engine and cell RAM.
//               Optional macro CMD_TIMEOUT_EN adds an inter-byte timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mem_cmd_ctrl #(
    parameter int          ADDR_W      = 16,
    parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              rx_perr,
    input  logic              rx_ferr,
    input  logic              rx_ovf,
    input  logic              tx_rdy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_addr_hi = 3'd1;
    localparam logic [2:0] c_st_addr_lo = 3'd2;
    localparam logic [2:0] c_st_data    = 3'd3;
    localparam logic [2:0] c_st_mem_wr  = 3'd4;
    localparam logic [2:0] c_st_mem_rd  = 3'd5;
    localparam logic [2:0] c_st_rd_lat  = 3'd6;
    localparam logic [2:0] c_st_tx_wait = 3'd7;

    localparam logic [7:0] c_op_write  = 8'h57;
    localparam logic [7:0] c_op_read   = 8'h52;
    localparam logic [7:0] c_rep_ok    = 8'h4B;
    localparam logic [7:0] c_rep_unkn  = 8'h3F;

    logic [2:0]        state_q, state_d;
    logic              op_wr_q, op_wr_d;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic [7:0]        reply_q, reply_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              busy_q, busy_d;
    logic              cmd_err_q, cmd_err_d;

    logic              w_rx_bad;
    logic              w_rx_ok;
    logic              w_tmo_hit;
    logic [15:0]       w_addr_full;

    assign w_rx_bad    = rx_rdy & (rx_perr | rx_ferr | rx_ovf);
    assign w_rx_ok     = rx_rdy & ~(rx_perr | rx_ferr | rx_ovf);
    assign w_addr_full = {addr_hi_q, rx_data};

`ifdef CMD_TIMEOUT_EN
    logic [19:0] tmo_q, tmo_d;
    logic        w_in_wait;

    assign w_in_wait = (state_q == c_st_addr_hi) || (state_q == c_st_addr_lo) ||
                       (state_q == c_st_data);
    assign w_tmo_hit = w_in_wait && !rx_rdy && (tmo_q == TIMEOUT_CYC - 20'd1);

    always_comb begin
        tmo_d = 20'd0;
        if (w_in_wait && !rx_rdy && !w_tmo_hit) begin
            tmo_d = tmo_q + 20'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            tmo_q <= 20'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        addr_hi_d   = addr_hi_q;
        reply_d     = reply_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        cmd_err_d   = 1'b0;

        case (state_q)
            c_st_idle: begin
                // A byte landing in the cycle the reply goes out is dropped.
                if (rx_rdy && (w_rx_bad || tx_start_q)) begin
                    cmd_err_d = 1'b1;
                end else if (w_rx_ok) begin
                    if (rx_data == c_op_write || rx_data == c_op_read) begin
                        op_wr_d = (rx_data == c_op_write);
                        state_d = c_st_addr_hi;
                    end else begin
                        reply_d = c_rep_unkn;
                        state_d = c_st_tx_wait;
                    end
                end
            end
            c_st_addr_hi, c_st_addr_lo, c_st_data: begin
                if (w_rx_bad || w_tmo_hit) begin
                    cmd_err_d = 1'b1;
                    state_d   = c_st_idle;
                end else if (w_rx_ok) begin
                    if (state_q == c_st_addr_hi) begin
                        addr_hi_d = rx_data;
                        state_d   = c_st_addr_lo;
                    end else if (state_q == c_st_addr_lo) begin
                        mem_addr_d = w_addr_full[ADDR_W-1:0];
                        state_d    = op_wr_q ? c_st_data : c_st_mem_rd;
                    end else begin
                        mem_wdata_d = rx_data;
                        mem_we_d    = 1'b1;
                        state_d     = c_st_mem_wr;
                    end
                end
            end
            c_st_mem_wr: begin
                cmd_err_d = rx_rdy;
                reply_d   = c_rep_ok;
                state_d   = c_st_tx_wait;
            end
            c_st_mem_rd: begin
                cmd_err_d = rx_rdy;
                state_d   = c_st_rd_lat;
            end
            c_st_rd_lat: begin
                cmd_err_d = rx_rdy;
                reply_d   = mem_rdata;
                state_d   = c_st_tx_wait;
            end
            c_st_tx_wait: begin
                cmd_err_d = rx_rdy;
                if (tx_rdy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = reply_q;
                    state_d    = c_st_idle;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase

        busy_d = (state_d != c_st_idle);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q     <= c_st_idle;
            op_wr_q     <= 1'b0;
            addr_hi_q   <= 8'h00;
            reply_q     <= 8'h00;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            mem_we_q    <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            addr_hi_q   <= addr_hi_d;
            reply_q     <= reply_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign cmd_err   = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mem_cmd_ctrl
// Description : Directed scoreboard bench for uart_mem_cmd_ctrl with RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mem_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_perr = 1'b0;
    logic        rx_ferr = 1'b0;
    logic        rx_ovf = 1'b0;
    logic        tx_rdy = 1'b1;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        cmd_err;

    int checks = 0;
    int errors = 0;
    int tx_seen = 0;
    int we_seen = 0;
    int err_seen = 0;
    logic prev_tx = 1'b0;
    logic [7:0]  txq[$];
    logic [23:0] wq[$];
    logic [7:0]  ram [0:65535];

    uart_mem_cmd_ctrl #(.ADDR_W(16), .TIMEOUT_CYC(20'd100)) dut (
        .clk(clk), .rstb(rstb), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_ovf(rx_ovf), .tx_rdy(tx_rdy),
        .tx_start(tx_start), .tx_data(tx_data), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_start) begin
            tx_seen++;
            check("tx_back_to_back", {31'd0, prev_tx}, 32'd0);
            check("tx_reply_expected", {31'd0, (txq.size() > 0)}, 32'd1);
            if (txq.size() > 0) check("tx_data", {24'd0, tx_data}, {24'd0, txq.pop_front()});
        end
        prev_tx = tx_start;
        if (mem_we) begin
            we_seen++;
            check("we_expected", {31'd0, (wq.size() > 0)}, 32'd1);
            if (wq.size() > 0) check("we_addr_data", {8'd0, mem_addr, mem_wdata}, {8'd0, wq.pop_front()});
        end
        if (cmd_err) err_seen++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic perr);
        @(negedge clk);
        rx_data = b; rx_perr = perr; rx_rdy = 1'b1;
        @(negedge clk);
        rx_rdy = 1'b0; rx_perr = 1'b0;
    endtask

    task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b0); idle(1);
        send_byte(b1, 1'b0); idle(1);
        send_byte(b2, 1'b0);
    endtask

    task automatic wait_tx(input int n0);
        int k = 0;
        while (tx_seen == n0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("tx_arrived", {31'd0, (tx_seen > n0)}, 32'd1);
        idle(3);
    endtask

    initial begin
        int t0, w0, e0;
        idle(3);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_mem", {7'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
        check("rst_busy_err", {30'd0, busy, cmd_err}, 32'd0);
        rstb = 1'b1;
        idle(2);

        // Write 0xA5 to address 5
        t0 = tx_seen; e0 = err_seen;
        wq.push_back({16'h0005, 8'hA5}); txq.push_back(8'h4B);
        send3(8'h57, 8'h00, 8'h05); idle(1);
        send_byte(8'hA5, 1'b0);
        check("wr_we_timing", {7'd0, mem_we, mem_addr, mem_wdata}, {7'd0, 1'b1, 16'h0005, 8'hA5});
        wait_tx(t0);
        check("wr_no_err", err_seen, e0);

        // Read it back
        t0 = tx_seen;
        txq.push_back(8'hA5);
        send3(8'h52, 8'h00, 8'h05);
        wait_tx(t0);

        // Unknown opcode
        t0 = tx_seen; w0 = we_seen; e0 = err_seen;
        txq.push_back(8'h3F);
        send_byte(8'h41, 1'b0);
        wait_tx(t0);
        idle(5);
        check("unk_one_reply", tx_seen, t0 + 1);
        check("unk_no_we", we_seen, w0);
        check("unk_no_err", err_seen, e0);

        // Parity error on addr_lo of a write
        t0 = tx_seen; w0 = we_seen; e0 = err_seen;
        send_byte(8'h57, 1'b0); idle(1);
        send_byte(8'h00, 1'b0); idle(1);
        send_byte(8'h07, 1'b1);
        check("perr_cmd_err", {31'd0, cmd_err}, 32'd1);
        check("perr_busy", {31'd0, busy}, 32'd0);
        idle(5);
        check("perr_no_we", we_seen, w0);
        check("perr_no_tx", tx_seen, t0);
        check("perr_err_cnt", err_seen, e0 + 1);
        t0 = tx_seen;
        txq.push_back(8'hA5);
        send3(8'h52, 8'h00, 8'h05);
        wait_tx(t0);

        // Transmitter stalled, stray byte injected while waiting
        tx_rdy = 1'b0;
        t0 = tx_seen;
        txq.push_back(8'hA5);
        send3(8'h52, 8'h00, 8'h05);
        idle(10);
        send_byte(8'h55, 1'b0);
        check("stall_drop_err", {31'd0, cmd_err}, 32'd1);
        idle(38);
        check("stall_no_tx", tx_seen, t0);
        check("stall_busy", {31'd0, busy}, 32'd1);
        tx_rdy = 1'b1;
        @(negedge clk);
        check("stall_tx_start", {23'd0, tx_start, tx_data}, {23'd0, 1'b1, 8'hA5});
        check("stall_busy_done", {31'd0, busy}, 32'd0);
        idle(3);

        // Partial command: timeout or indefinite wait
        e0 = err_seen;
        send_byte(8'h57, 1'b0); idle(1);
        send_byte(8'h00, 1'b0);
        idle(150);
`ifdef CMD_TIMEOUT_EN
        check("tmo_err", err_seen, e0 + 1);
        check("tmo_idle", {31'd0, busy}, 32'd0);
        send3(8'h57, 8'h00, 8'h06);
`else
        check("no_tmo_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h06, 1'b0);
`endif
        idle(1);
        check("data_state_busy", {31'd0, busy}, 32'd1);

        // Reset in DATA, then a full new write
        @(negedge clk); rstb = 1'b0;
        idle(2); rstb = 1'b1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_mem", {8'd0, mem_addr, mem_wdata}, 32'd0);
        t0 = tx_seen;
        wq.push_back({16'h0009, 8'h3C}); txq.push_back(8'h4B);
        send3(8'h57, 8'h00, 8'h09); idle(1);
        send_byte(8'h3C, 1'b0);
        wait_tx(t0);
        t0 = tx_seen;
        txq.push_back(8'h3C);
        send3(8'h52, 8'h00, 8'h09);
        wait_tx(t0);
        t0 = tx_seen;
        txq.push_back(8'hA5);
        send3(8'h52, 8'h00, 8'h05);
        wait_tx(t0);

        idle(5);
        check("txq_drained", txq.size(), 32'd0);
        check("wq_drained", wq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
